chunk_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port chunk ROM among `NUM_REQ` block-lookup requesters, such as parallel ray marchers and the collision unit. It accepts at most one lookup per cycle and drives the ROM address. It tracks each lookup through the fixed ROM read latency and returns the `BlockType` result to the requester that issued it. Out-of-bounds lookups are resolved locally as air and do not depend on ROM contents.

---
 rtl/chunk_arbiter_pkg.sv | 29 ++
 rtl/chunk_arbiter_if.sv | 26 ++
 rtl/chunk_arbiter_rr_pick.sv | 30 +++
 rtl/chunk_arbiter.sv | 86 ++++++++
 tb/tb_chunk_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chunk_arbiter_pkg.sv
// Shared voxel types for chunk ROM lookups: block positions, block ids and the chunk bounds test.
package chunk_arbiter_pkg;

   localparam int COORD_W     = 8;
   localparam int BLOCK_W     = 5;
   localparam int CHUNK_WIDTH = 16;

   typedef logic [BLOCK_W-1:0] BlockType;

   localparam BlockType BLOCK_AIR = '0;

   typedef struct packed {
      logic signed [COORD_W-1:0] x;
      logic signed [COORD_W-1:0] y;
      logic signed [COORD_W-1:0] z;
   } BlockPos;

   localparam logic signed [COORD_W-1:0] CHUNK_HI = COORD_W'(CHUNK_WIDTH);
   localparam logic signed [COORD_W-1:0] CHUNK_LO = COORD_W'(-CHUNK_WIDTH);

   function automatic logic coord_oob(logic signed [COORD_W-1:0] c);
      return (c >= CHUNK_HI) || (c < CHUNK_LO);
   endfunction

   function automatic logic pos_oob(BlockPos p);
      return coord_oob(p.x) || coord_oob(p.y) || coord_oob(p.z);
   endfunction

endpackage

// File: rtl/chunk_arbiter_if.sv
// Requester/ROM bundle of the chunk arbiter; slave is the arbiter, master the requesters plus ROM.
interface chunk_arbiter_if
   import chunk_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4
) ();

   logic    [NUM_REQ-1:0] req_valid;
   BlockPos [NUM_REQ-1:0] req_pos;
   logic    [NUM_REQ-1:0] req_ready;
   logic    [NUM_REQ-1:0] resp_valid;
   BlockType              resp_block;
   BlockPos               rom_addr;
   BlockType              rom_data;

   modport master (
      output req_valid, req_pos, rom_data,
      input  req_ready, resp_valid, resp_block, rom_addr
   );

   modport slave (
      input  req_valid, req_pos, rom_data,
      output req_ready, resp_valid, resp_block, rom_addr
   );

endinterface

// File: rtl/chunk_arbiter_rr_pick.sv
// Round-robin one-hot picker: first valid index strictly after last, wrapping.
module rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     valid,
   input  logic [IDX_W-1:0] last,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   int cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = 0;
      for (int k = 1; k <= N; k++) begin
         cand = (int'(last) + k) % N;
         if (!any && valid[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/chunk_arbiter.sv
// Shares the single-port chunk ROM among NUM_REQ requesters; fixed-latency tag pipe routes results back.
module chunk_arbiter
   import chunk_arbiter_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int ROM_LATENCY = 2
) (
   input  logic           clk_in,
   input  logic           rst_in,
   chunk_arbiter_if.slave bus
);

   localparam int REQ_IDX_W = $clog2(NUM_REQ);

   typedef struct packed {
      logic                 valid;
      logic [REQ_IDX_W-1:0] idx;
      logic                 oob;
   } tag_t;

   logic [REQ_IDX_W-1:0] last;
   logic [REQ_IDX_W-1:0] pick_idx;
   logic [NUM_REQ-1:0]   pick_grant;
   logic                 pick_any;
   logic                 xfer;
   BlockPos              issue_pos;
   tag_t                 issue_tag;
   tag_t                 tail;
   tag_t [ROM_LATENCY-1:0] pipe;
   logic [NUM_REQ-1:0]   resp_valid_c;
   BlockType             resp_block_c;

   rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (REQ_IDX_W)
   ) u_pick (
      .valid (bus.req_valid),
      .last  (last),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // No ROM backpressure, so any pick is a transfer unless reset holds grants off.
   assign xfer      = pick_any & ~rst_in;
   assign issue_pos = bus.req_pos[pick_idx];

   assign bus.req_ready = xfer ? pick_grant : '0;
   assign bus.rom_addr  = xfer ? issue_pos : '0;

   assign issue_tag.valid = xfer;
   assign issue_tag.idx   = pick_idx;
   assign issue_tag.oob   = pos_oob(issue_pos);

   assign tail = pipe[ROM_LATENCY-1];

   always_comb begin
      resp_valid_c = '0;
      resp_block_c = BLOCK_AIR;
      if (tail.valid && !rst_in) begin
         resp_valid_c[tail.idx] = 1'b1;
         if (!tail.oob) begin
            resp_block_c = bus.rom_data;
         end
      end
   end

   assign bus.resp_valid = resp_valid_c;
   assign bus.resp_block = resp_block_c;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         last <= REQ_IDX_W'(NUM_REQ - 1);
         pipe <= '0;
      end else begin
         if (xfer) begin
            last <= pick_idx;
         end
         pipe[0] <= issue_tag;
         for (int i = 1; i < ROM_LATENCY; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

endmodule

// File: tb/tb_chunk_arbiter.sv
// Directed table, hand-written corner sequences and a random scoreboard run for chunk_arbiter.
module tb_chunk_arbiter;
   import chunk_arbiter_pkg::*;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   chunk_arbiter_if #(.NUM_REQ(N)) bus ();

   chunk_arbiter #(.NUM_REQ(N), .ROM_LATENCY(2)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   // ROM model: two-cycle registered read, data = x+y+z+1, or a forced constant.
   BlockPos  rom_q1, rom_q2;
   logic     rom_force;
   BlockType rom_force_val;

   function automatic BlockType rom_fn(BlockPos p);
      return BlockType'(int'(p.x) + int'(p.y) + int'(p.z) + 1);
   endfunction

   always @(posedge clk) begin
      rom_q1 <= bus.rom_addr;
      rom_q2 <= rom_q1;
   end

   assign bus.rom_data = rom_force ? rom_force_val : rom_fn(rom_q2);

   function automatic BlockPos mk_pos(int x, int y, int z);
      BlockPos p;
      p.x = COORD_W'(x);
      p.y = COORD_W'(y);
      p.z = COORD_W'(z);
      return p;
   endfunction

   function automatic logic [31:0] pos_bits(BlockPos p);
      return {8'h00, p};
   endfunction

   function automatic logic tb_oob(BlockPos p);
      int c [3];
      c[0] = int'(p.x);
      c[1] = int'(p.y);
      c[2] = int'(p.z);
      for (int i = 0; i < 3; i++)
         if (c[i] >= CHUNK_WIDTH || c[i] < -CHUNK_WIDTH) return 1'b1;
      return 1'b0;
   endfunction

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req_valid = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [3:0] valid;
      logic [3:0] ready;
      logic [3:0] resp;
      logic [4:0] blk;
   } vec_t;

   vec_t     vecs [11];
   BlockPos  tbl_pos [N];
   BlockPos  oob_pos [4];
   BlockType oob_blk [4];
   logic [3:0] hold_valid [7];
   logic [3:0] hold_ready [7];
   BlockPos  exp_addr;
   logic [3:0] exp_g, exp_r, prev_grant;
   int       n_resp, m_last, best, gidx, d;
   logic [1:0] mp_v;
   int       mp_idx [2];
   BlockType mp_blk [2];

   initial begin
      rom_force     = 1'b0;
      rom_force_val = '0;
      bus.req_valid = '0;
      for (int i = 0; i < N; i++) begin
         tbl_pos[i]     = mk_pos(i + 1, 2 * i, -i);
         bus.req_pos[i] = tbl_pos[i];
      end

      // ---- reset state, with every requester asking ----
      rst = 1'b1;
      bus.req_valid = 4'b1111;
      @(negedge clk);
      check("rst_ready", 32'(bus.req_ready), 32'h0);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
      check("rst_resp_block", 32'(bus.resp_block), 32'h0);
      check("rst_rom_addr", pos_bits(bus.rom_addr), 32'h0);
      do_reset();

      // ---- table: per-cycle valid, expected grant/response (block per requester = 2i+2) ----
      vecs[0]  = '{4'b0100, 4'b0100, 4'b0000, 5'd0};
      vecs[1]  = '{4'b0000, 4'b0000, 4'b0000, 5'd0};
      vecs[2]  = '{4'b1111, 4'b1000, 4'b0100, 5'd6};
      vecs[3]  = '{4'b1111, 4'b0001, 4'b0000, 5'd0};
      vecs[4]  = '{4'b1111, 4'b0010, 4'b1000, 5'd8};
      vecs[5]  = '{4'b1010, 4'b1000, 4'b0001, 5'd2};
      vecs[6]  = '{4'b1010, 4'b0010, 4'b0010, 5'd4};
      vecs[7]  = '{4'b0001, 4'b0001, 4'b1000, 5'd8};
      vecs[8]  = '{4'b0000, 4'b0000, 4'b0010, 5'd4};
      vecs[9]  = '{4'b0000, 4'b0000, 4'b0001, 5'd2};
      vecs[10] = '{4'b0000, 4'b0000, 4'b0000, 5'd0};
      do_reset();
      foreach (vecs[v]) begin
         bus.req_valid = vecs[v].valid;
         @(negedge clk);
         exp_addr = '0;
         for (int i = 0; i < N; i++) if (vecs[v].ready[i]) exp_addr = tbl_pos[i];
         check($sformatf("tbl%0d_ready", v), 32'(bus.req_ready), 32'(vecs[v].ready));
         check($sformatf("tbl%0d_addr", v), pos_bits(bus.rom_addr), pos_bits(exp_addr));
         check($sformatf("tbl%0d_resp", v), 32'(bus.resp_valid), 32'(vecs[v].resp));
         if (vecs[v].resp != 4'b0000)
            check($sformatf("tbl%0d_blk", v), 32'(bus.resp_block), 32'(vecs[v].blk));
         next_cycle();
      end

      // ---- single request from requester 2 ----
      do_reset();
      bus.req_pos[2] = mk_pos(1, 2, 3);
      bus.req_valid  = 4'b0100;
      @(negedge clk);
      check("single_ready", 32'(bus.req_ready), 32'h4);
      check("single_addr", pos_bits(bus.rom_addr), pos_bits(mk_pos(1, 2, 3)));
      next_cycle();
      bus.req_valid = '0;
      @(negedge clk);
      check("single_resp_t1", 32'(bus.resp_valid), 32'h0);
      next_cycle();
      @(negedge clk);
      check("single_resp_t2", 32'(bus.resp_valid), 32'h4);
      check("single_blk_t2", 32'(bus.resp_block), 32'h7);
      next_cycle();
      @(negedge clk);
      check("single_resp_t3", 32'(bus.resp_valid), 32'h0);
      bus.req_pos[2] = tbl_pos[2];

      // ---- fairness: all four valid for 12 cycles ----
      do_reset();
      n_resp = 0;
      for (int k = 0; k < 14; k++) begin
         bus.req_valid = (k < 12) ? 4'b1111 : 4'b0000;
         @(negedge clk);
         exp_g = (k < 12) ? 4'(1 << (k % 4)) : 4'b0000;
         exp_r = (k >= 2) ? 4'(1 << ((k - 2) % 4)) : 4'b0000;
         check($sformatf("fair%0d_ready", k), 32'(bus.req_ready), 32'(exp_g));
         check($sformatf("fair%0d_resp", k), 32'(bus.resp_valid), 32'(exp_r));
         if (k >= 2)
            check($sformatf("fair%0d_blk", k), 32'(bus.resp_block), 32'(2 * ((k - 2) % 4) + 2));
         n_resp += $countones(bus.resp_valid);
         next_cycle();
      end
      check("fair_resp_count", 32'(n_resp), 32'd12);

      // ---- out of bounds vs. just-in-bounds, ROM driving all ones ----
      oob_pos[0] = mk_pos(CHUNK_WIDTH, 0, 0);       oob_blk[0] = 5'h00;
      oob_pos[1] = mk_pos(0, -CHUNK_WIDTH - 1, 0);  oob_blk[1] = 5'h00;
      oob_pos[2] = mk_pos(CHUNK_WIDTH - 1, 0, 0);   oob_blk[2] = 5'h1F;
      oob_pos[3] = mk_pos(0, 0, -CHUNK_WIDTH);      oob_blk[3] = 5'h1F;
      do_reset();
      rom_force     = 1'b1;
      rom_force_val = 5'h1F;
      for (int k = 0; k < 6; k++) begin
         if (k < 4) begin
            bus.req_valid  = 4'b0010;
            bus.req_pos[1] = oob_pos[k];
         end else begin
            bus.req_valid  = 4'b0000;
         end
         @(negedge clk);
         check($sformatf("oob%0d_ready", k), 32'(bus.req_ready), (k < 4) ? 32'h2 : 32'h0);
         if (k >= 2) begin
            check($sformatf("oob%0d_resp", k), 32'(bus.resp_valid), 32'h2);
            check($sformatf("oob%0d_blk", k), 32'(bus.resp_block), 32'(oob_blk[k-2]));
         end
         next_cycle();
      end
      rom_force = 1'b0;
      bus.req_pos[1] = tbl_pos[1];

      // ---- pointer hold and wrap ----
      hold_valid = '{4'b1000, 4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1001, 4'b1001};
      hold_ready = '{4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b1000, 4'b0001, 4'b1000};
      do_reset();
      for (int k = 0; k < 7; k++) begin
         bus.req_valid = hold_valid[k];
         @(negedge clk);
         check($sformatf("hold%0d_ready", k), 32'(bus.req_ready), 32'(hold_ready[k]));
         next_cycle();
      end
      bus.req_valid = '0;

      // ---- reset while lookups are in flight ----
      do_reset();
      bus.req_valid = 4'b0001;
      @(negedge clk);
      check("rmf_ready_t0", 32'(bus.req_ready), 32'h1);
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      check("rmf_ready_rst", 32'(bus.req_ready), 32'h0);
      check("rmf_resp_rst", 32'(bus.resp_valid), 32'h0);
      check("rmf_blk_rst", 32'(bus.resp_block), 32'h0);
      check("rmf_addr_rst", pos_bits(bus.rom_addr), 32'h0);
      next_cycle();
      rst = 1'b0;
      bus.req_valid = '0;
      @(negedge clk);
      check("rmf_resp_t2", 32'(bus.resp_valid), 32'h0);
      next_cycle();
      @(negedge clk);
      check("rmf_resp_t3", 32'(bus.resp_valid), 32'h0);
      next_cycle();
      bus.req_valid = 4'b0001;
      @(negedge clk);
      check("rmf_ready_new", 32'(bus.req_ready), 32'h1);
      next_cycle();
      bus.req_valid = '0;
      @(negedge clk);
      check("rmf_resp_new1", 32'(bus.resp_valid), 32'h0);
      next_cycle();
      @(negedge clk);
      check("rmf_resp_new2", 32'(bus.resp_valid), 32'h1);
      check("rmf_blk_new2", 32'(bus.resp_block), 32'(rom_fn(tbl_pos[0])));
      next_cycle();

      // ---- random valid patterns against a scoreboard ----
      do_reset();
      m_last     = N - 1;
      mp_v       = '0;
      mp_idx     = '{0, 0};
      mp_blk     = '{5'd0, 5'd0};
      prev_grant = '0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (!(bus.req_valid[i] && !prev_grant[i])) begin
               bus.req_valid[i] = ($urandom_range(0, 99) < 55);
               bus.req_pos[i]   = mk_pos(int'($urandom_range(0, 39)) - 20,
                                         int'($urandom_range(0, 39)) - 20,
                                         int'($urandom_range(0, 39)) - 20);
            end
         end
         @(negedge clk);
         best = N;
         gidx = 0;
         for (int j = 0; j < N; j++) begin
            if (bus.req_valid[j]) begin
               d = (j - m_last - 1 + 2 * N) % N;
               if (d < best) begin
                  best = d;
                  gidx = j;
               end
            end
         end
         exp_g = '0;
         if (best < N) exp_g[gidx] = 1'b1;
         exp_addr = (best < N) ? bus.req_pos[gidx] : '0;
         exp_r = '0;
         if (mp_v[1]) exp_r[mp_idx[1]] = 1'b1;
         check("rnd_ready", 32'(bus.req_ready), 32'(exp_g));
         check("rnd_ready_onehot0", 32'($onehot0(bus.req_ready)), 32'h1);
         check("rnd_addr", pos_bits(bus.rom_addr), pos_bits(exp_addr));
         check("rnd_resp", 32'(bus.resp_valid), 32'(exp_r));
         check("rnd_resp_onehot0", 32'($onehot0(bus.resp_valid)), 32'h1);
         if (mp_v[1]) check("rnd_blk", 32'(bus.resp_block), 32'(mp_blk[1]));
         mp_v[1]   = mp_v[0];
         mp_idx[1] = mp_idx[0];
         mp_blk[1] = mp_blk[0];
         mp_v[0]   = (best < N);
         mp_idx[0] = gidx;
         mp_blk[0] = tb_oob(exp_addr) ? BLOCK_AIR : rom_fn(exp_addr);
         if (best < N) m_last = gidx;
         prev_grant = exp_g;
         next_cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
